// File: rtl/bram_bank_loader_if.sv
// Bundle of the loader's stream input, BRAM write port and status lines.
// The bench or upstream logic holds the master side and the loader holds the slave side.
interface bram_bank_loader_if #(
  parameter int NUM_BANK = 16,
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 128
);
  logic                iLoadStart;
  logic                iValid;
  logic [DATA_W-1:0]   iData;
  logic                oReady;
  logic [NUM_BANK-1:0] o_ena;
  logic [NUM_BANK-1:0] o_wea;
  logic [ADDR_W-1:0]   o_addra;
  logic [DATA_W-1:0]   o_dia;
  logic                oBusy;
  logic                oStart;

  modport master (
    output iLoadStart, iValid, iData,
    input  oReady, o_ena, o_wea, o_addra, o_dia, oBusy, oStart
  );

  modport slave (
    input  iLoadStart, iValid, iData,
    output oReady, o_ena, o_wea, o_addra, o_dia, oBusy, oStart
  );
endinterface

// File: rtl/bram_bank_loader.sv
// Streams input words bank-major into NUM_BANK BRAM banks through a registered write port,
// then waits GAP_CYC cycles and raises a start level for the parsing stage.
module bram_bank_loader #(
  parameter int NUM_BANK = 16,
  parameter int DEPTH    = 128,
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 128,
  parameter int GAP_CYC  = 10
) (
  input logic               clk,
  input logic               rstn,
  bram_bank_loader_if.slave bus
);
  localparam int BANK_W = $clog2(NUM_BANK);
  localparam int CNT_W  = $clog2(DEPTH);
  localparam int GAP_W  = 8;

  localparam logic [BANK_W-1:0] BANK_LAST = BANK_W'(NUM_BANK - 1);
  localparam logic [CNT_W-1:0]  ADDR_LAST = CNT_W'(DEPTH - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [BANK_W-1:0]   bank_q, bank_d;
  logic [CNT_W-1:0]    addr_q, addr_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                start_q, start_d;
  logic [NUM_BANK-1:0] ena_q, ena_d;
  logic [ADDR_W-1:0]   addra_q, addra_d;
  logic [DATA_W-1:0]   dia_q, dia_d;
  logic                accept_s;

  // Next-state, counter and write-port logic.
  always_comb begin
    state_d  = state_q;
    bank_d   = bank_q;
    addr_d   = addr_q;
    gap_d    = gap_q;
    ena_d    = {NUM_BANK{1'b0}};
    addra_d  = addra_q;
    dia_d    = dia_q;
    accept_s = ready_q & bus.iValid;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.iLoadStart) begin
          state_d = ST_LOAD;
          bank_d  = {BANK_W{1'b0}};
          addr_d  = {CNT_W{1'b0}};
        end else begin
          state_d = state_q;
        end
      end
      ST_LOAD: begin
        if (accept_s) begin
          ena_d   = NUM_BANK'(1) << bank_q;
          addra_d = ADDR_W'(addr_q);
          dia_d   = bus.iData;
          if (addr_q == ADDR_LAST) begin
            addr_d = {CNT_W{1'b0}};
            if (bank_q == BANK_LAST) begin
              bank_d  = {BANK_W{1'b0}};
              gap_d   = {GAP_W{1'b0}};
              state_d = ST_GAP;
            end else begin
              bank_d = bank_q + BANK_W'(1);
            end
          end else begin
            addr_d = addr_q + CNT_W'(1);
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_GAP: begin
        // Counter runs 0..GAP_CYC-1, so GAP lasts exactly GAP_CYC cycles.
        if (gap_q == GAP_LAST) begin
          state_d = ST_DONE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ready_d = (state_d == ST_LOAD);
    busy_d  = (state_d == ST_LOAD) || (state_d == ST_GAP);
    start_d = (state_d == ST_DONE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      bank_q  <= {BANK_W{1'b0}};
      addr_q  <= {CNT_W{1'b0}};
      gap_q   <= {GAP_W{1'b0}};
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      ena_q   <= {NUM_BANK{1'b0}};
      addra_q <= {ADDR_W{1'b0}};
      dia_q   <= {DATA_W{1'b0}};
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      addr_q  <= addr_d;
      gap_q   <= gap_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      ena_q   <= ena_d;
      addra_q <= addra_d;
      dia_q   <= dia_d;
    end
  end

  assign bus.oReady  = ready_q;
  assign bus.oBusy   = busy_q;
  assign bus.oStart  = start_q;
  assign bus.o_ena   = ena_q;
  assign bus.o_wea   = ena_q;
  assign bus.o_addra = addra_q;
  assign bus.o_dia   = dia_q;
endmodule

// File: tb/tb_bram_bank_loader.sv
// Self-checking bench: a table of load scenarios plus hand-written reset and idle sequences;
// every accepted beat pushes its expected write onto a queue that is popped when the strobe appears.
module tb_bram_bank_loader;
  localparam int NUM_BANK = 16;
  localparam int DEPTH    = 128;
  localparam int ADDR_W   = 9;
  localparam int DATA_W   = 128;
  localparam int GAP_CYC  = 10;
  localparam int TOTAL_WR = NUM_BANK * DEPTH;

  logic clk;
  logic rstn;

  bram_bank_loader_if #(.NUM_BANK(NUM_BANK), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  bram_bank_loader #(
    .NUM_BANK(NUM_BANK), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .GAP_CYC(GAP_CYC)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]  ena;
    logic [8:0]   addr;
    logic [127:0] data;
  } exp_t;

  typedef struct {
    int valid_pct;
    bit pulse_load;
    bit pulse_gap;
    int exp_writes;
    int exp_gap;
  } vec_t;

  exp_t         q[$];
  vec_t         vecs[4];
  int           checks = 0;
  int           errors = 0;
  int           edge_n = 0;
  int           last_acc_edge = 0;
  int           wr_count = 0;
  int           pushed = 0;
  bit           pend = 1'b0;
  bit           load_done = 1'b0;
  logic [3:0]   m_bank = 4'd0;
  logic [6:0]   m_addr = 7'd0;
  logic [8:0]   last_addr = 9'd0;
  logic [127:0] last_data = 128'd0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Compare the write port for the cycle just begun against the scoreboard.
  task automatic check_write();
    exp_t e;
    if (pend) begin
      pend = 1'b0;
      e = q.pop_front();
      chk("wr_ena", 128'(bus.o_ena), 128'(e.ena));
      chk("wr_wea", 128'(bus.o_wea), 128'(e.ena));
      chk("wr_addr", 128'(bus.o_addra), 128'(e.addr));
      chk("wr_data", bus.o_dia, e.data);
      if (wr_count == 0) begin
        chk("first_ena", 128'(bus.o_ena), 128'h0001);
        chk("first_addr", 128'(bus.o_addra), 128'd0);
      end
      if (wr_count == 128) begin
        chk("bank1_ena", 128'(bus.o_ena), 128'h0002);
        chk("bank1_addr", 128'(bus.o_addra), 128'd0);
      end
      if (wr_count == TOTAL_WR - 1) begin
        chk("last_ena", 128'(bus.o_ena), 128'h8000);
        chk("last_addr", 128'(bus.o_addra), 128'd127);
      end
      last_addr = e.addr;
      last_data = e.data;
      wr_count++;
    end else begin
      chk("idle_ena", 128'(bus.o_ena), 128'd0);
      chk("idle_wea", 128'(bus.o_wea), 128'd0);
      chk("hold_addr", 128'(bus.o_addra), 128'(last_addr));
      chk("hold_data", bus.o_dia, last_data);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    edge_n++;
    #1;
    check_write();
  endtask

  // Drive one beat; if the loader is ready it will be accepted at the next edge.
  task automatic drive_beat(input bit v);
    logic [127:0] d;
    logic [15:0]  one;
    exp_t         e;
    one = 16'h0001;
    d = {$urandom(), $urandom(), $urandom(), $urandom()};
    d[10:0] = {m_bank, m_addr};
    bus.iValid = v;
    bus.iData  = d;
    if (v && bus.oReady) begin
      e.ena  = one << m_bank;
      e.addr = {2'b00, m_addr};
      e.data = d;
      q.push_back(e);
      pend = 1'b1;
      pushed++;
      if (m_bank == 4'd15 && m_addr == 7'd127) begin
        load_done = 1'b1;
        last_acc_edge = edge_n + 1;
      end
      if (m_addr == 7'd127) begin
        m_addr = 7'd0;
        m_bank = m_bank + 4'd1;
      end else begin
        m_addr = m_addr + 7'd1;
      end
    end
  endtask

  // Pulse iLoadStart together with iValid; that beat must not be taken.
  task automatic start_load();
    m_bank = 4'd0;
    m_addr = 7'd0;
    wr_count = 0;
    pushed = 0;
    load_done = 1'b0;
    bus.iLoadStart = 1'b1;
    drive_beat(1'b1);
    tick();
    bus.iLoadStart = 1'b0;
    chk("start_ready", 128'(bus.oReady), 128'd1);
    chk("start_ostart_low", 128'(bus.oStart), 128'd0);
    chk("start_busy", 128'(bus.oBusy), 128'd1);
  endtask

  task automatic run_load(input vec_t v);
    int  n;
    int  g;
    bit  pulsed;
    n = 0;
    pulsed = 1'b0;
    while (!load_done && n < 20000) begin
      bus.iLoadStart = v.pulse_load && !pulsed && (pushed == 1000);
      if (bus.iLoadStart) pulsed = 1'b1;
      drive_beat($urandom_range(99) < v.valid_pct);
      tick();
      n++;
    end
    bus.iLoadStart = 1'b0;
    chk("load_finished", 128'(load_done), 128'd1);
    chk("ready_after_last", 128'(bus.oReady), 128'd0);
    g = 0;
    while (!bus.oStart && g < GAP_CYC + 20) begin
      chk("gap_busy", 128'(bus.oBusy), 128'd1);
      chk("gap_ready", 128'(bus.oReady), 128'd0);
      bus.iLoadStart = v.pulse_gap && (g == 3);
      drive_beat(1'(($urandom() & 1)));
      tick();
      g++;
    end
    bus.iLoadStart = 1'b0;
    chk("ostart_high", 128'(bus.oStart), 128'd1);
    chk("ostart_latency", 128'(edge_n - last_acc_edge), 128'(v.exp_gap));
    chk("write_total", 128'(wr_count), 128'(v.exp_writes));
    chk("queue_empty", 128'(q.size()), 128'd0);
    for (int i = 0; i < 3; i++) begin
      drive_beat(1'b1);
      tick();
      chk("done_ostart", 128'(bus.oStart), 128'd1);
      chk("done_busy", 128'(bus.oBusy), 128'd0);
      chk("done_ready", 128'(bus.oReady), 128'd0);
    end
    bus.iValid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"}, 128'(bus.oReady), 128'd0);
    chk({tag, "_busy"}, 128'(bus.oBusy), 128'd0);
    chk({tag, "_ostart"}, 128'(bus.oStart), 128'd0);
    chk({tag, "_ena"}, 128'(bus.o_ena), 128'd0);
    chk({tag, "_addr"}, 128'(bus.o_addra), 128'd0);
    chk({tag, "_data"}, bus.o_dia, 128'd0);
  endtask

  initial begin
    vecs[0] = '{valid_pct: 100, pulse_load: 1'b0, pulse_gap: 1'b0, exp_writes: TOTAL_WR, exp_gap: GAP_CYC};
    vecs[1] = '{valid_pct: 50,  pulse_load: 1'b0, pulse_gap: 1'b0, exp_writes: TOTAL_WR, exp_gap: GAP_CYC};
    vecs[2] = '{valid_pct: 100, pulse_load: 1'b1, pulse_gap: 1'b1, exp_writes: TOTAL_WR, exp_gap: GAP_CYC};
    vecs[3] = '{valid_pct: 70,  pulse_load: 1'b1, pulse_gap: 1'b0, exp_writes: TOTAL_WR, exp_gap: GAP_CYC};

    rstn = 1'b0;
    bus.iLoadStart = 1'b0;
    bus.iValid = 1'b0;
    bus.iData = 128'd0;
    tick();
    check_all_zero("reset");
    tick();
    rstn = 1'b1;

    // iValid with no load request must never produce a write.
    for (int i = 0; i < 20; i++) begin
      drive_beat(1'b1);
      tick();
      chk("noload_ready", 128'(bus.oReady), 128'd0);
      chk("noload_ostart", 128'(bus.oStart), 128'd0);
    end
    bus.iValid = 1'b0;
    tick();

    for (int v = 0; v < 4; v++) begin
      start_load();
      run_load(vecs[v]);
    end

    // Reset mid-load at bank 3, address 50.
    start_load();
    while (pushed < 3 * 128 + 50) begin
      drive_beat(1'b1);
      tick();
    end
    chk("pre_reset_bank", 128'(m_bank), 128'd3);
    chk("pre_reset_addr", 128'(m_addr), 128'd50);
    rstn = 1'b0;
    bus.iValid = 1'b1;
    pend = 1'b0;
    q.delete();
    last_addr = 9'd0;
    last_data = 128'd0;
    tick();
    check_all_zero("midreset");
    rstn = 1'b1;
    bus.iValid = 1'b0;
    tick();
    tick();
    start_load();
    run_load(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
